// File: rtl/dc_dpcm_if.sv
// Stream interface for the multi-channel DC DPCM encoder: sample input, difference output and status flags.
interface dc_dpcm_if #(
  parameter int DW = 12
);
  logic [1:0]           mode;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] dc_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW:0]   dpcm_out;
  logic [1:0]           out_mode;
  logic                 out_last;
  logic                 frame_done;
  logic                 ovf_err;

  modport master (
    output mode, in_valid, dc_in, out_ready,
    input  in_ready, out_valid, dpcm_out, out_mode, out_last, frame_done, ovf_err
  );

  modport slave (
    input  mode, in_valid, dc_in, out_ready,
    output in_ready, out_valid, dpcm_out, out_mode, out_last, frame_done, ovf_err
  );
endinterface

// File: rtl/dc_dpcm_multi.sv
// Multi-channel (Y/Cr/Cb) DC-coefficient DPCM encoder with per-channel predictors and block counters.
// Optional macro DPCM_SAT_EN clamps the difference to the DW-bit signed range.
module dc_dpcm_multi #(
  parameter int DW    = 12,
  parameter int BLK_Y = 64,
  parameter int BLK_C = 16,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  dc_dpcm_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_FLUSH = 2'b10;

  logic [1:0]           state;
  logic signed [DW-1:0] pred [3];
  logic [CNT_W-1:0]     cnt  [3];

  logic                 vld_p1;
  logic signed [DW:0]   dpcm_p1;
  logic [1:0]           mode_p1;
  logic                 last_p1;
  logic                 frame_done_p1;
  logic                 ovf_err_r;

  logic                 accept, mode_ok, ch_full, take, ovf_hit, last_now, all_done, out_hs;
  logic [1:0]           ch;
  logic [2:0]           full;
  logic signed [DW-1:0] pred_sel;
  logic [CNT_W-1:0]     cnt_sel, cnt_inc, blk_sel;
  logic signed [DW:0]   diff_raw, diff;

  function automatic logic [CNT_W-1:0] blk_of(input int idx);
    return (idx == 0) ? CNT_W'(BLK_Y) : CNT_W'(BLK_C);
  endfunction

`ifdef DPCM_SAT_EN
  // Saturate a DW+1-bit difference into the DW-bit signed range, kept DW+1 wide.
  function automatic logic signed [DW:0] sat_dw(input logic signed [DW:0] v);
    if (v[DW] != v[DW-1])
      return v[DW] ? {2'b11, {(DW-1){1'b0}}} : {2'b00, {(DW-1){1'b1}}};
    return v;
  endfunction
`endif

  assign bus.in_ready   = ~clr & (state != S_FLUSH) & (~vld_p1 | bus.out_ready);
  assign bus.out_valid  = vld_p1;
  assign bus.dpcm_out   = dpcm_p1;
  assign bus.out_mode   = mode_p1;
  assign bus.out_last   = last_p1;
  assign bus.frame_done = frame_done_p1;
  assign bus.ovf_err    = ovf_err_r;

  always_comb begin
    accept   = bus.in_valid & bus.in_ready;
    mode_ok  = (bus.mode != 2'b00);
    ch       = bus.mode - 2'd1;
    pred_sel = '0;
    cnt_sel  = '0;
    blk_sel  = '0;
    case (bus.mode)
      2'b01:   begin pred_sel = pred[0]; cnt_sel = cnt[0]; blk_sel = blk_of(0); end
      2'b10:   begin pred_sel = pred[1]; cnt_sel = cnt[1]; blk_sel = blk_of(1); end
      2'b11:   begin pred_sel = pred[2]; cnt_sel = cnt[2]; blk_sel = blk_of(2); end
      default: ;
    endcase
    ch_full  = (cnt_sel == blk_sel);
    take     = accept & mode_ok & ~ch_full;
    ovf_hit  = accept & mode_ok & ch_full;
    cnt_inc  = cnt_sel + CNT_W'(1);
    last_now = (cnt_inc == blk_sel);
    out_hs   = vld_p1 & bus.out_ready;
    // Frame completes when every channel is full once this accept is counted.
    all_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      full[i] = (cnt[i] == blk_of(i));
      if (take && ch == 2'(i))
        all_done = all_done & last_now;
      else
        all_done = all_done & full[i];
    end
    diff_raw = {bus.dc_in[DW-1], bus.dc_in} - {pred_sel[DW-1], pred_sel};
`ifdef DPCM_SAT_EN
    diff = sat_dw(diff_raw);
`else
    diff = diff_raw;
`endif
  end

  // Stage p1: output register, predictor/counter update and frame FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      vld_p1        <= 1'b0;
      dpcm_p1       <= '0;
      mode_p1       <= 2'b00;
      last_p1       <= 1'b0;
      frame_done_p1 <= 1'b0;
      ovf_err_r     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        pred[i] <= '0;
        cnt[i]  <= '0;
      end
    end else if (clr) begin
      state         <= S_IDLE;
      vld_p1        <= 1'b0;
      dpcm_p1       <= '0;
      mode_p1       <= 2'b00;
      last_p1       <= 1'b0;
      frame_done_p1 <= 1'b0;
      ovf_err_r     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        pred[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      frame_done_p1 <= 1'b0;
      if (ovf_hit)
        ovf_err_r <= 1'b1;
      if (take) begin
        vld_p1  <= 1'b1;
        dpcm_p1 <= diff;
        mode_p1 <= bus.mode;
        last_p1 <= last_now;
        for (int i = 0; i < 3; i++) begin
          if (ch == 2'(i)) begin
            pred[i] <= bus.dc_in;
            cnt[i]  <= cnt_inc;
          end
        end
      end else if (out_hs) begin
        vld_p1 <= 1'b0;
      end
      case (state)
        S_IDLE:  if (take) state <= all_done ? S_FLUSH : S_RUN;
        S_RUN:   if (take && all_done) state <= S_FLUSH;
        S_FLUSH: begin
          // Final output of the frame leaves; rearm for the next frame.
          if (out_hs) begin
            state         <= S_IDLE;
            frame_done_p1 <= 1'b1;
            for (int i = 0; i < 3; i++) begin
              pred[i] <= '0;
              cnt[i]  <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_dpcm_multi.sv
// Directed bench for dc_dpcm_multi: channel DPCM, interleave, backpressure, frame end, overflow, clr and reset.
module tb_dc_dpcm_multi;
  localparam int DW = 12;

  logic clk;
  logic rst;
  logic clr;
  int   errors = 0;
  int   checks = 0;

  dc_dpcm_if #(.DW(DW)) bus ();

  dc_dpcm_multi #(.DW(DW), .BLK_Y(64), .BLK_C(16), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] m, input int d);
    bus.mode     = m;
    bus.dc_in    = DW'(d);
    bus.in_valid = 1'b1;
    #1 chk("in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // 64 Y, 16 Cr and 15 Cb samples; the last Cb is sent by the caller.
  task automatic frame_body();
    for (int i = 0; i < 64; i++) begin
      send(2'b01, 10 + 3 * i);
      chk("frm_y", bus.dpcm_out, (i == 0) ? 10 : 3);
      chk("frm_y_last", bus.out_last, (i == 63) ? 1 : 0);
    end
    for (int i = 0; i < 16; i++) begin
      send(2'b10, -5 * i);
      chk("frm_cr", bus.dpcm_out, (i == 0) ? 0 : -5);
      chk("frm_cr_last", bus.out_last, (i == 15) ? 1 : 0);
    end
    for (int i = 0; i < 15; i++) begin
      send(2'b11, 100 - 7 * i);
      chk("frm_cb", bus.dpcm_out, (i == 0) ? 100 : -7);
      chk("frm_cb_last", bus.out_last, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.mode = 2'b00;
    bus.dc_in = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_dpcm", bus.dpcm_out, 0);
    chk("rst_mode", bus.out_mode, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_fd", bus.frame_done, 0);
    chk("rst_ovf", bus.ovf_err, 0);
    chk("rst_rdy", bus.in_ready, 1);
    rst = 1'b0;

    send(2'b01, 100);
    chk("y0_vld", bus.out_valid, 1);
    chk("y0", bus.dpcm_out, 100);
    chk("y0_mode", bus.out_mode, 1);
    send(2'b01, 90);
    chk("y1", bus.dpcm_out, -10);
    send(2'b01, 95);
    chk("y2", bus.dpcm_out, 5);

    do_clr();
    chk("clr_vld", bus.out_valid, 0);
    send(2'b01, 50);
    chk("il_y0", bus.dpcm_out, 50);
    send(2'b11, -20);
    chk("il_cb0", bus.dpcm_out, -20);
    chk("il_cb0_mode", bus.out_mode, 3);
    send(2'b01, 60);
    chk("il_y1", bus.dpcm_out, 10);
    send(2'b11, -25);
    chk("il_cb1", bus.dpcm_out, -5);

    bus.out_ready = 1'b0;
    bus.mode = 2'b01;
    bus.dc_in = DW'(70);
    bus.in_valid = 1'b1;
    repeat (3) begin
      #1 chk("bp_rdy", bus.in_ready, 0);
      @(negedge clk);
      chk("bp_hold", bus.dpcm_out, -5);
      chk("bp_vld", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_resume_rdy", bus.in_ready, 1);
    @(negedge clk);
    chk("bp_y", bus.dpcm_out, 10);
    chk("bp_y_mode", bus.out_mode, 1);
    bus.mode = 2'b10;
    bus.dc_in = DW'(30);
    @(negedge clk);
    chk("bp_cr0", bus.dpcm_out, 30);
    chk("bp_cr0_mode", bus.out_mode, 2);
    bus.dc_in = DW'(25);
    @(negedge clk);
    chk("bp_cr1", bus.dpcm_out, -5);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_idle", bus.out_valid, 0);

    do_clr();
    frame_body();
    send(2'b11, 100 - 7 * 15);
    chk("frm_cb_end", bus.dpcm_out, -7);
    chk("frm_cb_end_last", bus.out_last, 1);
    chk("flush_rdy", bus.in_ready, 0);
    chk("flush_fd0", bus.frame_done, 0);
    @(negedge clk);
    chk("fd_pulse", bus.frame_done, 1);
    chk("fd_vld", bus.out_valid, 0);
    @(negedge clk);
    chk("fd_end", bus.frame_done, 0);
    send(2'b01, 7);
    chk("next_y", bus.dpcm_out, 7);
    chk("next_y_last", bus.out_last, 0);

    for (int i = 0; i < 16; i++) begin
      send(2'b10, -5 * i);
      chk("ov_cr", bus.dpcm_out, (i == 0) ? 0 : -5);
    end
    chk("ov_cr_last", bus.out_last, 1);
    send(2'b10, 99);
    chk("ov_drop", bus.out_valid, 0);
    chk("ov_err", bus.ovf_err, 1);
    send(2'b01, 10);
    chk("ov_y", bus.dpcm_out, 3);
    chk("ov_sticky", bus.ovf_err, 1);
    do_clr();
    chk("ov_clr", bus.ovf_err, 0);

    frame_body();
    send(2'b11, 100 - 7 * 15);
    chk("cf_last", bus.out_last, 1);
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("cf_hold", bus.out_valid, 1);
    chk("cf_rdy", bus.in_ready, 0);
    clr = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("cf_vld", bus.out_valid, 0);
    chk("cf_fd", bus.frame_done, 0);
    @(negedge clk);
    chk("cf_fd_after", bus.frame_done, 0);
    send(2'b01, 7);
    chk("cf_next_y", bus.dpcm_out, 7);

    do_clr();
    send(2'b01, -2048);
    chk("sat_y0", bus.dpcm_out, -2048);
    send(2'b01, 2047);
`ifdef DPCM_SAT_EN
    chk("sat_y1", bus.dpcm_out, 2047);
`else
    chk("sat_y1", bus.dpcm_out, 4095);
`endif
    send(2'b00, 123);
    chk("m00_vld", bus.out_valid, 0);
    chk("m00_ovf", bus.ovf_err, 0);
    send(2'b01, 2000);
    chk("m00_y", bus.dpcm_out, -47);

    send(2'b01, 500);
    chk("arst_pre", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", bus.out_valid, 0);
    chk("arst_dpcm", bus.dpcm_out, 0);
    @(negedge clk);
    rst = 1'b0;
    send(2'b01, 8);
    chk("arst_y", bus.dpcm_out, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
